data_mem_unit: RTL and testbench
================================

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter cRamDepth, default 1024 (package value), data RAM depth in 32-bit words; power of two.
REQ-002 iClk  input  1  single clock, all state on rising edge.
REQ-003 iRstN  input  1  asynchronous, active-low reset.
REQ-004 iMemOp  input  tMemOp  request from ALU stage; read/write act as valid; addr byte address; data store data; opType load/store width code (funct3); rdAddr load destination.
REQ-005 oStall  output  1  high while a load is in flight; upstream holds iMemOp and issues nothing new.
REQ-006 oRegOp  output  tRegOp  load writeback: dv, addr (=rdAddr), data (extended load value).
REQ-007 oErr  output  1  one-cycle pulse on a rejected request.

Function
REQ-008 Request accepted only in IDLE, when exactly one of read/write is high; a request seen in any other state is ignored.
REQ-009 States: IDLE, RD_WAIT, RD_RESP; IDLE->RD_WAIT on accepted load; RD_WAIT->RD_RESP unconditionally; RD_RESP->IDLE unconditionally.
REQ-010 Stores complete in IDLE: RAM byte-write on the accept edge; no state change; oStall stays low; back-to-back stores every cycle.
REQ-011 Load latency: accept at edge N; RAM data valid after edge N+1; oRegOp.dv high for exactly one cycle after edge N+2.
REQ-012 oStall high in RD_WAIT and RD_RESP, low in IDLE; combinational decode of state only.
REQ-013 Word index = addr[log2(cRamDepth)+1:2]; upper address bits ignored (aliasing, no range error).
REQ-014 Store widths: opType 000 byte (lane addr[1:0]), 001 halfword (lanes addr[1]), 010 word (all lanes); data taken from low bits of iMemOp.data, replicated into the addressed lanes.
REQ-015 Load widths: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; lane selected by the addr[1:0] registered at accept.
REQ-016 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0), undefined opType (load 011/110/111, store >=011), or read and write both high: no RAM access, no state change, oErr pulses the following cycle.
REQ-017 Load with rdAddr = 0 performs the full sequence with oStall but oRegOp.dv stays 0.
REQ-018 oRegOp.addr and oRegOp.data hold their last values when dv=0; consumers qualify with dv.
REQ-019 RAM contents are not initialised by reset; read-before-write returns undefined data.

Reset
REQ-020 On iRstN low: state IDLE, oStall 0, oRegOp = cRegOp (all zero), oErr 0, registered addr/opType/rdAddr cleared.
REQ-021 Reset asserted mid-load aborts it; no oRegOp.dv after reset release; pending store not retried.
REQ-022 First request is accepted on the first rising edge with iRstN high.

Structure
REQ-023 tMemOp, tRegOp, cRegOp, cXLEN, cRegSelBitW, cRamDepth come from the shared core package; add there load/store width constants (cMemByte 000, cMemHalf 001, cMemWord 010, cMemByteU 100, cMemHalfU 101) and the state enum tMemStateEnum.
REQ-024 One sub-module, data_ram: cRamDepth x 32, 4 byte-write enables, one synchronous read port with 1-cycle latency, no reset; the FSM, lane steering and extension remain in data_mem_unit.

Verification
REQ-025 SW data 0x8765_4321 addr 0x10, then LW rd=5 addr 0x10 -> oStall high 2 cycles, oRegOp {dv=1, addr=5, data=0x8765_4321} 2 cycles after accept.
REQ-026 After REQ-025: LB addr 0x13 -> 0xFFFF_FF87; LBU addr 0x13 -> 0x0000_0087; LH addr 0x12 -> 0xFFFF_8765; LHU addr 0x10 -> 0x0000_4321.
REQ-027 SB 0xAA addr 0x11 then LW addr 0x10 -> 0x8765_AA21; SH 0xBEEF addr 0x12 then LW -> 0xBEEF_AA21.
REQ-028 LW addr 0x12, SH addr 0x01, read and write both high -> oErr one-cycle pulse each, oStall low, no oRegOp.dv, RAM word 0x10 unchanged.
REQ-029 LW rd=0 -> oStall 2 cycles, no dv; new request held during stall is accepted only on return to IDLE, exactly once.
REQ-030 iRstN low in RD_WAIT -> all outputs zero immediately; no dv after release; next LW returns correct data.

Source files
------------

// File: rtl/data_mem_unit_pkg.sv
// Shared core types for the load/store unit: request/writeback structs, width codes, FSM states.
package data_mem_unit_pkg;

    localparam int cXLEN       = 32;
    localparam int cRegSelBitW = 5;
    localparam int cRamDepth   = 1024;

    localparam logic [2:0] cMemByte  = 3'b000;
    localparam logic [2:0] cMemHalf  = 3'b001;
    localparam logic [2:0] cMemWord  = 3'b010;
    localparam logic [2:0] cMemByteU = 3'b100;
    localparam logic [2:0] cMemHalfU = 3'b101;

    typedef struct packed {
        logic                   read;
        logic                   write;
        logic [cXLEN-1:0]       addr;
        logic [cXLEN-1:0]       data;
        logic [2:0]             opType;
        logic [cRegSelBitW-1:0] rdAddr;
    } tMemOp;

    typedef struct packed {
        logic                   dv;
        logic [cRegSelBitW-1:0] addr;
        logic [cXLEN-1:0]       data;
    } tRegOp;

    localparam tRegOp cRegOp = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_RESP = 2'd2
    } tMemStateEnum;

endpackage

// File: rtl/data_mem_unit_ram.sv
// Word-wide data RAM with per-byte write enables; synchronous read, 1-cycle latency.
// No reset and no backpressure: contents are undefined until written.
module data_ram
    import data_mem_unit_pkg::*;
#(
    parameter int cRamDepth = data_mem_unit_pkg::cRamDepth,
    parameter int cIdxW     = $clog2(cRamDepth)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic [cIdxW-1:0] waddr,
    input  logic [cXLEN-1:0] wdata,
    input  logic [cIdxW-1:0] raddr,
    output logic [cXLEN-1:0] rdata
);

    logic [cXLEN-1:0] mem [cRamDepth];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store unit: stores write in one cycle, loads write back two cycles after accept.
// Backpressure: oStall holds upstream for the two load cycles; requests seen while busy are ignored.
module data_mem_unit
    import data_mem_unit_pkg::*;
#(
    parameter int cRamDepth = data_mem_unit_pkg::cRamDepth
) (
    input  logic  iClk,
    input  logic  iRstN,
    input  tMemOp iMemOp,
    output logic  oStall,
    output tRegOp oRegOp,
    output logic  oErr
);

    localparam int cIdxW = $clog2(cRamDepth);

    tMemStateEnum           state;
    logic [cIdxW-1:0]       rd_idx;
    logic [1:0]             rd_lane;
    logic [2:0]             rd_type;
    logic [cRegSelBitW-1:0] rd_dest;

    logic [cXLEN-1:0] ram_rdata;
    logic [cXLEN-1:0] ram_wdata;
    logic [3:0]       ram_we;
    logic [cXLEN-1:0] load_val;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    logic [1:0] lane;
    logic       req_seen, misaligned, bad_type, accept_ld, accept_st, reject;
    logic       unused_addr;

    assign lane        = iMemOp.addr[1:0];
    assign unused_addr = ^iMemOp.addr[cXLEN-1:cIdxW+2];

    always_comb begin
        req_seen   = iMemOp.read | iMemOp.write;
        misaligned = 1'b0;
        bad_type   = 1'b0;
        case (iMemOp.opType)
            cMemByte:  misaligned = 1'b0;
            cMemHalf:  misaligned = lane[0];
            cMemWord:  misaligned = |lane;
            cMemByteU: bad_type   = iMemOp.write;
            cMemHalfU: begin
                misaligned = lane[0];
                bad_type   = iMemOp.write;
            end
            default:   bad_type   = 1'b1;
        endcase
        accept_ld = (state == IDLE) && iMemOp.read && !iMemOp.write && !misaligned && !bad_type;
        accept_st = (state == IDLE) && iMemOp.write && !iMemOp.read && !misaligned && !bad_type;
        reject    = (state == IDLE) && req_seen && !accept_ld && !accept_st;
    end

    // Store data is replicated across lanes; the byte enables pick the addressed ones.
    always_comb begin
        ram_we    = 4'b0000;
        ram_wdata = iMemOp.data;
        if (accept_st) begin
            case (iMemOp.opType)
                cMemByte: begin
                    ram_we    = 4'b0001 << lane;
                    ram_wdata = {4{iMemOp.data[7:0]}};
                end
                cMemHalf: begin
                    ram_we    = lane[1] ? 4'b1100 : 4'b0011;
                    ram_wdata = {2{iMemOp.data[15:0]}};
                end
                default: ram_we = 4'b1111;
            endcase
        end
    end

    always_comb begin
        byte_sel = ram_rdata[{rd_lane, 3'b000} +: 8];
        half_sel = rd_lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (rd_type)
            cMemByte:  load_val = {{(cXLEN-8){byte_sel[7]}}, byte_sel};
            cMemHalf:  load_val = {{(cXLEN-16){half_sel[15]}}, half_sel};
            cMemByteU: load_val = {{(cXLEN-8){1'b0}}, byte_sel};
            cMemHalfU: load_val = {{(cXLEN-16){1'b0}}, half_sel};
            default:   load_val = ram_rdata;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state   <= IDLE;
            rd_idx  <= '0;
            rd_lane <= '0;
            rd_type <= '0;
            rd_dest <= '0;
            oRegOp  <= cRegOp;
            oErr    <= 1'b0;
        end else begin
            oErr      <= reject;
            oRegOp.dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_ld) begin
                        state   <= RD_WAIT;
                        rd_idx  <= iMemOp.addr[cIdxW+1:2];
                        rd_lane <= lane;
                        rd_type <= iMemOp.opType;
                        rd_dest <= iMemOp.rdAddr;
                    end
                end
                RD_WAIT: state <= RD_RESP;
                RD_RESP: begin
                    state <= IDLE;
                    // x0 is never written; addr/data keep their previous values too.
                    if (rd_dest != '0) begin
                        oRegOp.dv   <= 1'b1;
                        oRegOp.addr <= rd_dest;
                        oRegOp.data <= load_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oStall = (state != IDLE);

    data_ram #(
        .cRamDepth (cRamDepth)
    ) u_ram (
        .clk   (iClk),
        .we    (ram_we),
        .waddr (iMemOp.addr[cIdxW+1:2]),
        .wdata (ram_wdata),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: byte-level reference model, per-cycle compare, directed literal cases.
module tb_data_mem_unit;
    import data_mem_unit_pkg::*;

    localparam int NB = cRamDepth * 4;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    tMemOp mem_op = '0;
    logic  stall;
    tRegOp reg_op;
    logic  err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    data_mem_unit #(.cRamDepth(cRamDepth)) dut (
        .iClk   (clk),
        .iRstN  (rst_n),
        .iMemOp (mem_op),
        .oStall (stall),
        .oRegOp (reg_op),
        .oErr   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory and a countdown for the in-flight load.
    logic [7:0]  mbyte  [NB];
    bit          mknown [NB];
    int          busy     = 0;
    logic [4:0]  p_dest   = '0;
    logic [31:0] p_val    = '0;
    bit          p_known  = 1'b0;
    logic        e_stall  = 1'b0;
    logic        e_err    = 1'b0;
    logic        e_dv     = 1'b0;
    logic [4:0]  e_addr   = '0;
    logic [31:0] e_data   = '0;
    bit          e_dknown = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 0; e_stall = 0; e_err = 0; e_dv = 0;
            e_addr = '0; e_data = '0; e_dknown = 1'b1;
        end else begin
            e_err = 1'b0;
            e_dv  = 1'b0;
            if (busy == 2) begin
                busy = 1;
            end else if (busy == 1) begin
                busy = 0;
                if (p_dest != 0) begin
                    e_dv = 1'b1; e_addr = p_dest; e_data = p_val; e_dknown = p_known;
                end
            end else if (mem_op.read || mem_op.write) begin
                int size, base;
                bit sgn, legal;
                size = 0; sgn = 1'b0;
                case (mem_op.opType)
                    3'd0: begin size = 1; sgn = 1'b1; end
                    3'd1: begin size = 2; sgn = 1'b1; end
                    3'd2: size = 4;
                    3'd4: size = 1;
                    3'd5: size = 2;
                    default: size = 0;
                endcase
                base  = int'(mem_op.addr % NB);
                legal = (mem_op.read != mem_op.write) && size != 0 && (base % size == 0)
                        && !(mem_op.write && mem_op.opType > 3'd2);
                if (!legal) begin
                    e_err = 1'b1;
                end else if (mem_op.write) begin
                    for (int i = 0; i < size; i++) begin
                        mbyte[base+i]  = mem_op.data[8*i +: 8];
                        mknown[base+i] = 1'b1;
                    end
                end else begin
                    p_val   = '0;
                    p_known = 1'b1;
                    for (int i = 0; i < size; i++) begin
                        p_val[8*i +: 8] = mbyte[base+i];
                        p_known = p_known && mknown[base+i];
                    end
                    if (size == 1 && sgn) p_val = {{24{p_val[7]}}, p_val[7:0]};
                    if (size == 2 && sgn) p_val = {{16{p_val[15]}}, p_val[15:0]};
                    p_dest = mem_op.rdAddr;
                    busy   = 2;
                end
            end
            e_stall = (busy != 0);
        end
    end

    // Per-cycle comparison plus event counters used by the directed cases.
    int          dv_count = 0, err_count = 0, stall_count = 0, last_dv_cyc = 0;
    logic [31:0] last_dv_data = '0;
    logic [4:0]  last_dv_addr = '0;

    always @(negedge clk) begin
        chk("stall", stall, e_stall);
        chk("err", err, e_err);
        chk("dv", reg_op.dv, e_dv);
        chk("wb_addr", reg_op.addr, e_addr);
        if (e_dknown) chk("wb_data", reg_op.data, e_data);
        if (reg_op.dv) begin
            dv_count++;
            last_dv_cyc  = cyc;
            last_dv_data = reg_op.data;
            last_dv_addr = reg_op.addr;
        end
        if (err)   err_count++;
        if (stall) stall_count++;
    end

    // Presents a request and holds it while stalled; returns the cycle of the edge that took it.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] ty, input logic [4:0] dest, output int acc_cyc);
        bit was_stalled;
        int guard;
        guard = 0;
        mem_op.read = rd; mem_op.write = wr; mem_op.addr = addr;
        mem_op.data = data; mem_op.opType = ty; mem_op.rdAddr = dest;
        do begin
            was_stalled = stall;
            @(posedge clk);
            @(negedge clk);
            guard++;
        end while (was_stalled && guard < 20);
        if (guard >= 20) chk("accept_bound", 0, 1);
        acc_cyc = cyc;
        mem_op.read  = 1'b0;
        mem_op.write = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_op.read  = 1'b0;
        mem_op.write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic load_chk(input string name, input logic [31:0] addr, input logic [2:0] ty,
                            input logic [31:0] exp);
        int acc, d0;
        d0 = dv_count;
        issue(1, 0, addr, 32'h0, ty, 5'd7, acc);
        idle(4);
        chk({name, "_dv_once"}, dv_count - d0, 1);
        chk(name, last_dv_data, exp);
    endtask

    initial begin
        int acc, acc2, s0, d0, e0;
        logic [31:0] a;
        logic [2:0]  ty;
        int r;

        repeat (3) @(negedge clk);
        chk("reset_stall", stall, 0);
        chk("reset_regop", reg_op, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;

        // Word store then word load to x5: two stall cycles, writeback two cycles after accept.
        issue(0, 1, 32'h10, 32'h8765_4321, cMemWord, 5'd0, acc);
        s0 = stall_count;
        issue(1, 0, 32'h10, 32'h0, cMemWord, 5'd5, acc);
        idle(4);
        chk("lw_stall_cycles", stall_count - s0, 2);
        chk("lw_latency", last_dv_cyc - acc, 2);
        chk("lw_dest", last_dv_addr, 5);
        chk("lw_data", last_dv_data, 32'h8765_4321);

        load_chk("lb_13",  32'h13, cMemByte,  32'hFFFF_FF87);
        load_chk("lbu_13", 32'h13, cMemByteU, 32'h0000_0087);
        load_chk("lh_12",  32'h12, cMemHalf,  32'hFFFF_8765);
        load_chk("lhu_10", 32'h10, cMemHalfU, 32'h0000_4321);

        issue(0, 1, 32'h11, 32'h1234_56AA, cMemByte, 5'd0, acc);
        load_chk("sb_merge", 32'h10, cMemWord, 32'h8765_AA21);
        issue(0, 1, 32'h12, 32'h5555_BEEF, cMemHalf, 5'd0, acc);
        load_chk("sh_merge", 32'h10, cMemWord, 32'hBEEF_AA21);

        // Rejected requests: one error pulse each, no stall, no writeback, memory untouched.
        s0 = stall_count; d0 = dv_count; e0 = err_count;
        issue(1, 0, 32'h12, 32'h0, cMemWord, 5'd3, acc);
        idle(3);
        chk("err_lw_mis", err_count - e0, 1);
        issue(0, 1, 32'h01, 32'hFFFF_FFFF, cMemHalf, 5'd0, acc);
        idle(3);
        chk("err_sh_mis", err_count - e0, 2);
        issue(1, 1, 32'h10, 32'h0, cMemWord, 5'd4, acc);
        idle(3);
        chk("err_both", err_count - e0, 3);
        chk("err_no_stall", stall_count - s0, 0);
        chk("err_no_dv", dv_count - d0, 0);
        load_chk("err_mem_kept", 32'h10, cMemWord, 32'hBEEF_AA21);

        // Load to x0 followed by a request held through the stall.
        s0 = stall_count; d0 = dv_count;
        issue(1, 0, 32'h10, 32'h0, cMemWord, 5'd0, acc);
        issue(1, 0, 32'h13, 32'h0, cMemByteU, 5'd9, acc2);
        idle(5);
        chk("held_accept_gap", acc2 - acc, 3);
        chk("x0_single_dv", dv_count - d0, 1);
        chk("held_dest", last_dv_addr, 9);
        chk("held_data", last_dv_data, 32'h0000_00BE);
        chk("x0_held_stall", stall_count - s0, 4);

        // Reset during RD_WAIT aborts the load.
        issue(1, 0, 32'h10, 32'h0, cMemWord, 5'd6, acc);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_regop", reg_op, 0);
        chk("midrst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = dv_count;
        idle(4);
        chk("midrst_no_dv", dv_count - d0, 0);
        load_chk("post_rst_lw", 32'h10, cMemWord, 32'hBEEF_AA21);

        // Random traffic over a 16-word window with aliased upper address bits.
        for (int w = 0; w < 16; w++)
            issue(0, 1, ($urandom & 32'hFFFF_F000) | (w * 4), $urandom, cMemWord, 5'd0, acc);
        for (int i = 0; i < 400; i++) begin
            a  = ($urandom & 32'hFFFF_F000) | $urandom_range(0, 63);
            r  = $urandom_range(0, 9);
            ty = (r < 8) ? ((r < 2) ? 3'd0 : (r < 4) ? 3'd1 : (r < 6) ? 3'd2 : (r == 6) ? 3'd4 : 3'd5)
                         : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) != 0)
                a[1:0] = (ty[1:0] == 2'd2) ? 2'b00 : (ty[0] ? {a[1], 1'b0} : a[1:0]);
            r = $urandom_range(0, 19);
            issue(r < 9 || r >= 18, r >= 9, a, $urandom, ty, 5'($urandom_range(0, 31)), acc);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
